// File: rtl/adi_spi_pkg.sv
// Shared types and elaboration-time helpers for the ADI-style SPI master.
package adi_spi_pkg;

    typedef enum logic [2:0] {
        ST_POR,
        ST_IDLE,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_CS_HOLD,
        ST_DONE
    } spi_state_t;

    // clk cycles per sclk half-period (integer division)
    function automatic int calc_half(input int clk_fre, input int sclk_fre);
        return clk_fre / (2 * sclk_fre);
    endfunction

    // serial frame: R/W bit, address, data
    function automatic int calc_frame_len(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/adi_spi_clk_gen.sv
// Half-period tick generator. While en is high it emits one strobe every
// HALF clk cycles, alternating rise/fall, starting with a rise. Dropping en
// rewinds the counter and phase so the next frame starts cleanly.
module adi_spi_clk_gen #(
    parameter int HALF = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             phase_reg;
    logic             half_tick;

    assign half_tick = en && (cnt_reg == CNT_LAST);
    assign rise_tick = half_tick && !phase_reg;
    assign fall_tick = half_tick && phase_reg;

    // half-period counter and sclk phase tracker
    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            cnt_reg   <= '0;
            phase_reg <= 1'b0;
        end else if (half_tick) begin
            cnt_reg   <= '0;
            phase_reg <= ~phase_reg;
        end else begin
            cnt_reg   <= cnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/adi_spi_master_param.sv
// Parameterised SPI register-access master for ADI-style converters.
// Frame = R/W bit, address, data, MSB first; sclk idles low, master updates
// sdio on falling edges, read data sampled on rising edges.
// Optional macro ADI_SPI_4WIRE_EN: adds an sdo input used for read data and
// keeps sdio driven (dir tied high). Default build is 3-wire with turnaround.
module adi_spi_master_param
    import adi_spi_pkg::*;
#(
    parameter int CLK_FRE    = 100_000_000,
    parameter int SCLK_FRE   = 1_000_000,
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 8,
    parameter int RST_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              user_wr_en,
    input  logic [ADDR_W-1:0] user_wr_addr,
    input  logic [DATA_W-1:0] user_wr_data,
    input  logic              user_rd_en,
    input  logic [ADDR_W-1:0] user_rd_addr,
    output logic [DATA_W-1:0] user_rd_data,
    output logic              user_op_busy,
    output logic              user_wr_vild,
    output logic              user_rd_vild,
    output logic              rst_spi_pin,
    output logic              scb,
    output logic              sclk,
`ifdef ADI_SPI_4WIRE_EN
    input  logic              sdo,
`endif
    inout  wire               sdio,
    output logic              dir
);

    localparam int HALF  = calc_half(CLK_FRE, SCLK_FRE);
    localparam int FRAME = calc_frame_len(ADDR_W, DATA_W);
    localparam int RC_W  = $clog2(FRAME + 1);
    localparam int POR_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [RC_W-1:0]  FRAME_CNT  = RC_W'(FRAME);
    localparam logic [RC_W-1:0]  DATA_START = RC_W'(1 + ADDR_W);
    localparam logic [POR_W-1:0] POR_LAST   = POR_W'((RST_CYCLES > 0) ? RST_CYCLES - 1 : 0);

    // refuse to elaborate with an unusable configuration
    generate
        if (HALF < 2) begin : g_bad_half
            $error("adi_spi_master_param: CLK_FRE/(2*SCLK_FRE) must be >= 2");
        end
        if (ADDR_W < 5 || ADDR_W > 15) begin : g_bad_addr_w
            $error("adi_spi_master_param: ADDR_W out of range 5..15");
        end
        if (DATA_W < 8 || DATA_W > 32) begin : g_bad_data_w
            $error("adi_spi_master_param: DATA_W out of range 8..32");
        end
    endgenerate

    spi_state_t        state_reg, state_next;
    logic [POR_W-1:0]  por_cnt_reg, por_cnt_next;
    logic [FRAME-1:0]  tx_reg, tx_next;
    logic [DATA_W-1:0] rx_reg, rx_next;
    logic [RC_W-1:0]   rise_cnt_reg, rise_cnt_next;
    logic              is_read_reg, is_read_next;
    logic              sclk_reg, sclk_next;
    logic              scb_reg, scb_next;
    logic              sdio_reg, sdio_next;
    logic              dir_reg, dir_next;
    logic              rst_pin_reg, rst_pin_next;
    logic [DATA_W-1:0] rd_data_reg, rd_data_next;
    logic              wr_vild_reg, wr_vild_next;
    logic              rd_vild_reg, rd_vild_next;

    logic [FRAME-1:0]  load_frame;
    logic              sdi;
    logic              tick_en;
    logic              rise_tick;
    logic              fall_tick;

    // a simultaneous write and read resolves to the write
    assign load_frame = user_wr_en ? {1'b0, user_wr_addr, user_wr_data}
                                   : {1'b1, user_rd_addr, {DATA_W{1'b0}}};

    assign tick_en = (state_reg == ST_CS_SETUP) || (state_reg == ST_SHIFT) ||
                     (state_reg == ST_CS_HOLD);

    adi_spi_clk_gen #(
        .HALF(HALF)
    ) u_clk_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (tick_en),
        .rise_tick(rise_tick),
        .fall_tick(fall_tick)
    );

`ifdef ADI_SPI_4WIRE_EN
    assign sdio = sdio_reg;
    assign sdi  = sdo;
`else
    assign sdio = dir_reg ? sdio_reg : 1'bz;
    assign sdi  = sdio;
`endif

    assign user_rd_data = rd_data_reg;
    assign user_op_busy = (state_reg != ST_IDLE);
    assign user_wr_vild = wr_vild_reg;
    assign user_rd_vild = rd_vild_reg;
    assign rst_spi_pin  = rst_pin_reg;
    assign scb          = scb_reg;
    assign sclk         = sclk_reg;
    assign dir          = dir_reg;

    // next-state and next-output logic for the frame sequencer
    always_comb begin
        state_next    = state_reg;
        por_cnt_next  = por_cnt_reg;
        tx_next       = tx_reg;
        rx_next       = rx_reg;
        rise_cnt_next = rise_cnt_reg;
        is_read_next  = is_read_reg;
        sclk_next     = sclk_reg;
        scb_next      = scb_reg;
        sdio_next     = sdio_reg;
        dir_next      = dir_reg;
        rst_pin_next  = rst_pin_reg;
        rd_data_next  = rd_data_reg;
        wr_vild_next  = 1'b0;
        rd_vild_next  = 1'b0;

        case (state_reg)
            ST_POR: begin
                if (por_cnt_reg == POR_LAST) begin
                    state_next   = ST_IDLE;
                    rst_pin_next = 1'b1;
                end else begin
                    por_cnt_next = por_cnt_reg + POR_W'(1);
                end
            end
            ST_IDLE: begin
                if (user_wr_en || user_rd_en) begin
                    state_next    = ST_CS_SETUP;
                    is_read_next  = !user_wr_en;
                    scb_next      = 1'b0;
                    sclk_next     = 1'b0;
                    dir_next      = 1'b1;
                    rise_cnt_next = '0;
                    rx_next       = '0;
                    sdio_next     = load_frame[FRAME-1];
                    tx_next       = load_frame << 1;
                end
            end
            ST_CS_SETUP: begin
                if (rise_tick) begin
                    state_next    = ST_SHIFT;
                    sclk_next     = 1'b1;
                    rise_cnt_next = rise_cnt_reg + RC_W'(1);
                end
            end
            ST_SHIFT: begin
                if (rise_tick) begin
                    sclk_next     = 1'b1;
                    rise_cnt_next = rise_cnt_reg + RC_W'(1);
                    if (is_read_reg && (rise_cnt_reg >= DATA_START)) begin
                        rx_next = {rx_reg[DATA_W-2:0], sdi};
                    end
                end else if (fall_tick) begin
                    sclk_next = 1'b0;
                    if (rise_cnt_reg == FRAME_CNT) begin
                        state_next = ST_CS_HOLD;
                        sdio_next  = 1'b0;
                    end else begin
                        // rise_cnt_reg is the index of the bit now being launched
                        sdio_next = tx_reg[FRAME-1];
                        tx_next   = tx_reg << 1;
`ifndef ADI_SPI_4WIRE_EN
                        if (is_read_reg && (rise_cnt_reg >= DATA_START)) begin
                            dir_next = 1'b0;
                        end
`endif
                    end
                end
            end
            ST_CS_HOLD: begin
                if (rise_tick) begin
                    state_next = ST_DONE;
                    scb_next   = 1'b1;
                    dir_next   = 1'b1;
                    if (is_read_reg) begin
                        rd_data_next = rx_reg;
                        rd_vild_next = 1'b1;
                    end else begin
                        wr_vild_next = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_POR;
            end
        endcase
    end

    // state and output registers; reset aborts any frame in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_POR;
            por_cnt_reg  <= '0;
            tx_reg       <= '0;
            rx_reg       <= '0;
            rise_cnt_reg <= '0;
            is_read_reg  <= 1'b0;
            sclk_reg     <= 1'b0;
            scb_reg      <= 1'b1;
            sdio_reg     <= 1'b0;
            dir_reg      <= 1'b1;
            rst_pin_reg  <= 1'b0;
            rd_data_reg  <= '0;
            wr_vild_reg  <= 1'b0;
            rd_vild_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            por_cnt_reg  <= por_cnt_next;
            tx_reg       <= tx_next;
            rx_reg       <= rx_next;
            rise_cnt_reg <= rise_cnt_next;
            is_read_reg  <= is_read_next;
            sclk_reg     <= sclk_next;
            scb_reg      <= scb_next;
            sdio_reg     <= sdio_next;
            dir_reg      <= dir_next;
            rst_pin_reg  <= rst_pin_next;
            rd_data_reg  <= rd_data_next;
            wr_vild_reg  <= wr_vild_next;
            rd_vild_reg  <= rd_vild_next;
        end
    end

endmodule

// File: tb/tb_adi_spi_master_param.sv
// Directed bench for adi_spi_master_param: default instance (7/8 bits) plus
// a wide instance (10/16 bits). Honours ADI_SPI_4WIRE_EN when defined.
module tb_adi_spi_master_param;

    localparam int RST_CYC = 1000;
    localparam int HALF    = 50;
    localparam int MAXW    = 20000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // default instance
    logic        wr_en = 1'b0, rd_en = 1'b0;
    logic [6:0]  wr_addr = '0, rd_addr = '0;
    logic [7:0]  wr_data = '0;
    logic [7:0]  rd_data;
    logic        busy, wr_vild, rd_vild, rst_pin, scb, sclk, dir;
    wire         sdio;
    logic        slave_bit = 1'b0;
    logic [7:0]  slave_data = '0;

    // wide instance
    logic        w_wr_en = 1'b0;
    logic [9:0]  w_wr_addr = '0;
    logic [15:0] w_wr_data = '0;
    logic [15:0] w_rd_data;
    logic        w_busy, w_wr_vild, w_rd_vild, w_rst_pin, w_scb, w_sclk, w_dir;
    wire         w_sdio;

    int errors = 0;
    int checks = 0;

    // monitor state, default instance
    int          cyc = 0;
    int          rises = 0, dir_low_rises = 0, dir_low_cycles = 0, frames = 0;
    int          wr_pulses = 0, rd_pulses = 0;
    int          t_scb_fall = 0, t_rise1 = 0, t_fall1 = 0, t_fall_last = 0, t_scb_rise = 0;
    logic [31:0] cap = '0;
    logic        sclk_prev = 1'b0, scb_prev = 1'b1;

    // monitor state, wide instance
    int          w_rises = 0, w_wr_pulses = 0;
    logic [31:0] w_cap = '0;
    logic        w_sclk_prev = 1'b0;

    always #5 clk = ~clk;

`ifdef ADI_SPI_4WIRE_EN
    localparam int EXP_DIR_LOW = 0;
`else
    localparam int EXP_DIR_LOW = 8;
    assign sdio = dir ? 1'bz : slave_bit;
`endif

    adi_spi_master_param #(
        .RST_CYCLES(RST_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .user_wr_en  (wr_en),
        .user_wr_addr(wr_addr),
        .user_wr_data(wr_data),
        .user_rd_en  (rd_en),
        .user_rd_addr(rd_addr),
        .user_rd_data(rd_data),
        .user_op_busy(busy),
        .user_wr_vild(wr_vild),
        .user_rd_vild(rd_vild),
        .rst_spi_pin (rst_pin),
        .scb         (scb),
        .sclk        (sclk),
`ifdef ADI_SPI_4WIRE_EN
        .sdo         (slave_bit),
`endif
        .sdio        (sdio),
        .dir         (dir)
    );

    adi_spi_master_param #(
        .ADDR_W    (10),
        .DATA_W    (16),
        .RST_CYCLES(RST_CYC)
    ) dut_wide (
        .clk         (clk),
        .rst_n       (rst_n),
        .user_wr_en  (w_wr_en),
        .user_wr_addr(w_wr_addr),
        .user_wr_data(w_wr_data),
        .user_rd_en  (1'b0),
        .user_rd_addr(10'd0),
        .user_rd_data(w_rd_data),
        .user_op_busy(w_busy),
        .user_wr_vild(w_wr_vild),
        .user_rd_vild(w_rd_vild),
        .rst_spi_pin (w_rst_pin),
        .scb         (w_scb),
        .sclk        (w_sclk),
`ifdef ADI_SPI_4WIRE_EN
        .sdo         (1'b0),
`endif
        .sdio        (w_sdio),
        .dir         (w_dir)
    );

    // bus monitor and slave model for the default instance, sampled mid-cycle
    always @(negedge clk) begin
        cyc++;
        if (!dir) dir_low_cycles++;
        if (sclk && !sclk_prev) begin
            cap = {cap[30:0], sdio};
            rises++;
            if (!dir) dir_low_rises++;
            if (rises == 1) t_rise1 = cyc;
        end
        if (!sclk && sclk_prev) begin
            if (rises == 1) t_fall1 = cyc;
            t_fall_last = cyc;
            if (rises >= 8 && rises < 16) slave_bit = slave_data[15 - rises];
        end
        if (!scb && scb_prev) begin
            t_scb_fall = cyc;
            frames++;
        end
        if (scb && !scb_prev) t_scb_rise = cyc;
        if (wr_vild) wr_pulses++;
        if (rd_vild) rd_pulses++;
        sclk_prev = sclk;
        scb_prev  = scb;
    end

    // bus monitor for the wide instance
    always @(negedge clk) begin
        if (w_sclk && !w_sclk_prev) begin
            w_cap = {w_cap[30:0], w_sdio};
            w_rises++;
        end
        if (w_wr_vild) w_wr_pulses++;
        w_sclk_prev = w_sclk;
    end

    task automatic clear_mon();
        rises = 0; dir_low_rises = 0; dir_low_cycles = 0; frames = 0;
        wr_pulses = 0; rd_pulses = 0; cap = '0; slave_bit = 1'b0;
        w_rises = 0; w_wr_pulses = 0; w_cap = '0;
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (scb !== 1'b1) begin errors++; $display("FAIL reset_scb got=%b exp=1", scb); end
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk got=%b exp=0", sclk); end
        checks++; if (dir !== 1'b1) begin errors++; $display("FAIL reset_dir got=%b exp=1", dir); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b exp=1", busy); end
        checks++; if (rst_pin !== 1'b0) begin errors++; $display("FAIL reset_rst_pin got=%b exp=0", rst_pin); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
        checks++; if (wr_vild !== 1'b0 || rd_vild !== 1'b0) begin errors++; $display("FAIL reset_vild got=%b%b exp=00", wr_vild, rd_vild); end
        // a request during POR must be ignored
        wr_addr = 7'h01; wr_data = 8'h01; wr_en = 1'b1;
        rst_n = 1'b1;
        @(negedge clk); wr_en = 1'b0;
        n = 1;
        while (!rst_pin && n < MAXW) begin @(negedge clk); n++; end
        checks++; if (n != RST_CYC) begin errors++; $display("FAIL por_length got=%0d exp=%0d", n, RST_CYC); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL por_exit_busy got=%b exp=0", busy); end
        checks++; if (frames != 0) begin errors++; $display("FAIL por_req_ignored frames=%0d exp=0", frames); end
        $display("reset: por_cycles=%0d busy=%b", n, busy);
    endtask

    task automatic test_write();
        int n;
        clear_mon();
        wr_addr = 7'h4A; wr_data = 8'h55; wr_en = 1'b1;
        @(negedge clk); wr_en = 1'b0;
        n = 0;
        while (busy && n < MAXW) begin @(negedge clk); n++; end
        checks++; if (busy) begin errors++; $display("FAIL write_timeout busy=%b exp=0", busy); end
        checks++; if (rises != 16) begin errors++; $display("FAIL write_rises got=%0d exp=16", rises); end
        checks++; if (cap[15:0] !== 16'h4A55) begin errors++; $display("FAIL write_stream got=%h exp=4a55", cap[15:0]); end
        checks++; if (wr_pulses != 1 || rd_pulses != 0) begin errors++; $display("FAIL write_vild wr=%0d rd=%0d exp=1/0", wr_pulses, rd_pulses); end
        checks++; if (t_rise1 - t_scb_fall != HALF) begin errors++; $display("FAIL write_cs_setup got=%0d exp=%0d", t_rise1 - t_scb_fall, HALF); end
        checks++; if (t_fall1 - t_rise1 != HALF) begin errors++; $display("FAIL write_half got=%0d exp=%0d", t_fall1 - t_rise1, HALF); end
        checks++; if (t_scb_rise - t_fall_last != HALF) begin errors++; $display("FAIL write_cs_hold got=%0d exp=%0d", t_scb_rise - t_fall_last, HALF); end
        checks++; if (scb !== 1'b1 || sclk !== 1'b0) begin errors++; $display("FAIL write_idle_bus scb=%b sclk=%b exp=1/0", scb, sclk); end
        $display("write: addr=4a data=55 stream=%h rises=%0d wr_vild=%0d", cap[15:0], rises, wr_pulses);
    endtask

    task automatic test_read();
        int n;
        clear_mon();
        slave_data = 8'hAA;
        rd_addr = 7'h5A; rd_en = 1'b1;
        @(negedge clk); rd_en = 1'b0;
        n = 0;
        while (busy && n < MAXW) begin @(negedge clk); n++; end
        checks++; if (busy) begin errors++; $display("FAIL read_timeout busy=%b exp=0", busy); end
        checks++; if (cap[15:8] !== 8'hDA) begin errors++; $display("FAIL read_header got=%h exp=da", cap[15:8]); end
        checks++; if (rd_data !== 8'hAA) begin errors++; $display("FAIL read_data got=%h exp=aa", rd_data); end
        checks++; if (rd_pulses != 1 || wr_pulses != 0) begin errors++; $display("FAIL read_vild rd=%0d wr=%0d exp=1/0", rd_pulses, wr_pulses); end
        checks++; if (dir_low_rises != EXP_DIR_LOW) begin errors++; $display("FAIL read_dir_low got=%0d exp=%0d", dir_low_rises, EXP_DIR_LOW); end
        checks++; if (dir !== 1'b1) begin errors++; $display("FAIL read_dir_after got=%b exp=1", dir); end
        $display("read: addr=5a rd_data=%h dir_low_rises=%0d rd_vild=%0d", rd_data, dir_low_rises, rd_pulses);
    endtask

    task automatic test_collision();
        int n;
        clear_mon();
        wr_addr = 7'h11; wr_data = 8'h3C; rd_addr = 7'h22;
        wr_en = 1'b1; rd_en = 1'b1;
        @(negedge clk); wr_en = 1'b0; rd_en = 1'b0;
        repeat (10) @(negedge clk);
        wr_addr = 7'h7F; wr_data = 8'hFF; wr_en = 1'b1;
        @(negedge clk); wr_en = 1'b0;
        n = 0;
        while (busy && n < MAXW) begin @(negedge clk); n++; end
        repeat (300) @(negedge clk);
        checks++; if (busy) begin errors++; $display("FAIL collision_timeout busy=%b exp=0", busy); end
        checks++; if (frames != 1) begin errors++; $display("FAIL collision_frames got=%0d exp=1", frames); end
        checks++; if (cap[15:0] !== 16'h113C) begin errors++; $display("FAIL collision_stream got=%h exp=113c", cap[15:0]); end
        checks++; if (wr_pulses != 1 || rd_pulses != 0) begin errors++; $display("FAIL collision_vild wr=%0d rd=%0d exp=1/0", wr_pulses, rd_pulses); end
        $display("collision: frames=%0d stream=%h wr_vild=%0d rd_vild=%0d", frames, cap[15:0], wr_pulses, rd_pulses);
    endtask

    task automatic test_wide();
        int n;
        clear_mon();
        w_wr_addr = 10'h123; w_wr_data = 16'hBEEF; w_wr_en = 1'b1;
        @(negedge clk); w_wr_en = 1'b0;
        n = 0;
        while (w_busy && n < MAXW) begin @(negedge clk); n++; end
        checks++; if (w_busy) begin errors++; $display("FAIL wide_timeout busy=%b exp=0", w_busy); end
        checks++; if (w_rises != 27) begin errors++; $display("FAIL wide_rises got=%0d exp=27", w_rises); end
        checks++; if ((w_cap & 32'h07FF_FFFF) !== 32'h0123_BEEF) begin errors++; $display("FAIL wide_stream got=%h exp=0123beef", w_cap & 32'h07FF_FFFF); end
        checks++; if (w_wr_pulses != 1) begin errors++; $display("FAIL wide_vild got=%0d exp=1", w_wr_pulses); end
        $display("wide: addr=123 data=beef stream=%h rises=%0d", w_cap & 32'h07FF_FFFF, w_rises);
    endtask

`ifdef ADI_SPI_4WIRE_EN
    task automatic test_4wire();
        int n;
        clear_mon();
        slave_data = 8'h3C;
        rd_addr = 7'h33; rd_en = 1'b1;
        @(negedge clk); rd_en = 1'b0;
        n = 0;
        while (busy && n < MAXW) begin @(negedge clk); n++; end
        checks++; if (busy) begin errors++; $display("FAIL 4wire_timeout busy=%b exp=0", busy); end
        checks++; if (rd_data !== 8'h3C) begin errors++; $display("FAIL 4wire_data got=%h exp=3c", rd_data); end
        checks++; if (dir_low_cycles != 0) begin errors++; $display("FAIL 4wire_dir_low_cycles got=%0d exp=0", dir_low_cycles); end
        checks++; if (cap[15:0] !== 16'hB300) begin errors++; $display("FAIL 4wire_sdio got=%h exp=b300", cap[15:0]); end
        $display("4wire: addr=33 rd_data=%h dir_low_cycles=%0d", rd_data, dir_low_cycles);
    endtask
`endif

    task automatic test_reset_mid();
        int n;
        clear_mon();
        wr_addr = 7'h2B; wr_data = 8'hC3; wr_en = 1'b1;
        @(negedge clk); wr_en = 1'b0;
        n = 0;
        while (rises < 5 && n < MAXW) begin @(negedge clk); n++; end
        checks++; if (rises != 5) begin errors++; $display("FAIL midrst_reach_bit5 rises=%0d exp=5", rises); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (scb !== 1'b1 || sclk !== 1'b0) begin errors++; $display("FAIL midrst_bus scb=%b sclk=%b exp=1/0", scb, sclk); end
        checks++; if (rst_pin !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL midrst_por rst_pin=%b busy=%b exp=0/1", rst_pin, busy); end
        rst_n = 1'b1;
        n = 0;
        while (!rst_pin && n < MAXW) begin @(negedge clk); n++; end
        checks++; if (n != RST_CYC) begin errors++; $display("FAIL midrst_por_length got=%0d exp=%0d", n, RST_CYC); end
        repeat (20) @(negedge clk);
        checks++; if (wr_pulses != 0 || rd_pulses != 0) begin errors++; $display("FAIL midrst_no_vild wr=%0d rd=%0d exp=0/0", wr_pulses, rd_pulses); end
        checks++; if (rises != 5) begin errors++; $display("FAIL midrst_aborted rises=%0d exp=5", rises); end
        $display("reset_mid: por_cycles=%0d rises=%0d vild=%0d", n, rises, wr_pulses + rd_pulses);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_collision();
        test_wide();
`ifdef ADI_SPI_4WIRE_EN
        test_4wire();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adi_spi_master_param.md
ADI_SPI_MASTER_PARAM -- requirements
Module: adi_spi_master_param

Interface
REQ-001 SHALL have parameter CLK_FRE, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter SCLK_FRE, default 1_000_000, SPI serial clock frequency in Hz.
REQ-003 SHALL have parameter ADDR_W, default 7, register address width, legal range 5..15.
REQ-004 SHALL have parameter DATA_W, default 8, register data width, legal range 8..32.
REQ-005 SHALL have parameter RST_CYCLES, default 1000, clk cycles that rst_spi_pin is held low after reset.
REQ-006 clk  input  1  system clock, all logic on rising edge.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 user_wr_en  input  1  one-cycle write request.
REQ-009 user_wr_addr  input  ADDR_W  write address.
REQ-010 user_wr_data  input  DATA_W  write data.
REQ-011 user_rd_en  input  1  one-cycle read request.
REQ-012 user_rd_addr  input  ADDR_W  read address.
REQ-013 user_rd_data  output  DATA_W  last read result, held until the next read completes.
REQ-014 user_op_busy  output  1  high while in any state other than IDLE.
REQ-015 user_wr_vild  output  1  one-cycle pulse on write completion.
REQ-016 user_rd_vild  output  1  one-cycle pulse on read completion, same cycle user_rd_data updates.
REQ-017 rst_spi_pin  output  1  slave hardware reset, active-low.
REQ-018 scb  output  1  slave chip select, active-low.
REQ-019 sclk  output  1  serial clock, idle low.
REQ-020 sdio  inout  1  bidirectional serial data; high-Z whenever dir=0.
REQ-021 dir  output  1  external buffer direction: 1 = master drives, 0 = slave drives.

Function
REQ-022 Frame SHALL be 1+ADDR_W+DATA_W bits, MSB first: R/W bit (1 = read), address, data.
REQ-023 HALF = CLK_FRE/(2*SCLK_FRE) clk cycles per sclk half-period, integer division, minimum 2 (checked at elaboration).
REQ-024 States SHALL be POR, IDLE, CS_SETUP, SHIFT, CS_HOLD, DONE.
REQ-025 POR: rst_spi_pin=0 for RST_CYCLES, then rst_spi_pin=1 and go to IDLE; requests are ignored.
REQ-026 IDLE: request latched on the cycle it is seen; wr_en and rd_en in the same cycle -> write wins, read dropped.
REQ-027 Requests arriving while user_op_busy=1 SHALL be ignored and not queued.
REQ-028 CS_SETUP: scb=0 for HALF cycles with sclk low and the first bit on sdio.
REQ-029 SHIFT: sclk toggles every HALF cycles; master changes sdio on the falling edge; read data is sampled on the rising edge.
REQ-030 Read: dir=0 and sdio released starting at the falling edge after the last address bit, through the end of the frame.
REQ-031 CS_HOLD: after the last rising edge, sclk returns low; scb stays 0 for HALF cycles, then 1.
REQ-032 DONE: lasts one cycle; pulses the matching *_vild; then IDLE.
REQ-033 Exactly 1+ADDR_W+DATA_W sclk rising edges per frame.

Reset
REQ-034 rst_n=0 SHALL, on the next clk edge, force: state POR, scb=1, sclk=0, dir=1, sdio=0, user_rd_data=0, busy=1, vild=0, rst_spi_pin=0.
REQ-035 Reset asserted mid-frame SHALL abort the frame immediately; no vild pulse is issued and no partial user_rd_data is written.

Configuration
REQ-036 With ADI_SPI_4WIRE_EN defined: add input sdo (1 bit); read data is sampled from sdo; dir is tied to 1 and sdio always drives, with 0 during the data phase of reads.
REQ-037 Without ADI_SPI_4WIRE_EN: 3-wire operation as in REQ-030; no sdo port.

Structure
REQ-038 Package adi_spi_pkg SHALL hold the state enum and the function computing HALF and frame length.
REQ-039 Sub-module adi_spi_clk_gen SHALL generate the rise/fall tick strobes from HALF; the FSM consumes those ticks.

Verification
REQ-040 Defaults; write addr 0x4A, data 0x55 -> sdio = 0_1001010_01010101 over 16 rising edges, HALF=50, one wr_vild pulse, scb high afterwards.
REQ-041 Defaults; read addr 0x5A, slave drives 0xAA in the data phase -> dir=0 for 8 bits, user_rd_data=0xAA with one rd_vild pulse.
REQ-042 ADDR_W=10, DATA_W=16; write addr 0x123, data 0xBEEF -> 27 rising edges with the correct serial stream.
REQ-043 wr_en and rd_en in the same cycle, then a second wr_en while busy -> only the first write is executed; exactly one wr_vild and no rd_vild.
REQ-044 rst_n low during bit 5 -> scb=1 the next cycle, no vild, rst_spi_pin low for RST_CYCLES.
REQ-045 With ADI_SPI_4WIRE_EN, read with sdo driving 0x3C -> user_rd_data=0x3C and dir stays 1 throughout.
